// File: rtl/sb_pkg.sv
// Shared types for the store buffer: entry layout, drain FSM states, default depth.
package sb_pkg;

   localparam int unsigned SB_DEPTH = 4;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } sb_entry_t;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_REQ  = 1'b1
   } sb_state_t;

endpackage

// File: rtl/sb_fwd.sv
// Store-to-load forwarding: youngest held entry whose word address matches the load wins.
module sb_fwd
   import sb_pkg::*;
#(
   parameter int unsigned DEPTH = SB_DEPTH
) (
   input  sb_entry_t                  entries [DEPTH],
   input  logic [$clog2(DEPTH)-1:0]   head,
   input  logic [$clog2(DEPTH):0]     count,
   input  logic [31:0]                ld_addr,
   input  logic [31:0]                ld_mem_data,
   output logic [31:0]                ld_data
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

   logic [PW-1:0] idx;

   // Walk oldest to youngest so the last hit is the youngest match.
   always_comb begin
      ld_data = ld_mem_data;
      idx     = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         idx = head + PW'(i);
         if ((CW'(i) < count) && (((entries[idx].addr ^ ld_addr) & WORD_MASK) == '0))
            ld_data = entries[idx].data;
      end
   end

endmodule

// File: rtl/store_buffer.sv
// Circular store buffer between core and data memory with in-order drain and load forwarding.
module store_buffer
   import sb_pkg::*;
#(
   parameter int unsigned DEPTH = SB_DEPTH
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       st_valid,
   input  logic [31:0]                st_addr,
   input  logic [31:0]                st_data,
   output logic                       stall,
   input  logic [31:0]                ld_addr,
   output logic [31:0]                ld_data,
   output logic [31:0]                ld_mem_addr,
   input  logic [31:0]                ld_mem_data,
   output logic                       mem_req,
   output logic [31:0]                mem_addr,
   output logic [31:0]                mem_wdata,
   input  logic                       mem_ack,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   sb_entry_t     entries [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   sb_state_t     state;
   sb_state_t     state_next;
   logic          enq;
   logic          pop;

   // Fullness is judged on registered count, so a same-cycle pop never releases stall.
   assign stall       = st_valid & (count == FULL);
   assign enq         = st_valid & (count != FULL);
   assign pop         = mem_req & mem_ack;
   assign empty       = (count == '0);
   assign mem_addr    = entries[head].addr;
   assign mem_wdata   = entries[head].data;
   assign ld_mem_addr = ld_addr;

   always_ff @(posedge clk) begin
      if (enq)
         entries[tail] <= '{addr: st_addr, data: st_data};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         state <= S_IDLE;
      end else begin
         if (enq)
            tail <= tail + PW'(1);
         if (pop)
            head <= head + PW'(1);
         case ({enq, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         state <= state_next;
      end
   end

   // Entering REQ on the enqueue edge gives mem_req in the very next cycle.
   always_comb begin
      state_next = state;
      mem_req    = 1'b0;
      case (state)
         S_IDLE: begin
            if (enq)
               state_next = S_REQ;
         end
         S_REQ: begin
            mem_req = 1'b1;
            if (pop && !enq && (count == CW'(1)))
               state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   sb_fwd #(
      .DEPTH (DEPTH)
   ) u_fwd (
      .entries     (entries),
      .head        (head),
      .count       (count),
      .ld_addr     (ld_addr),
      .ld_mem_data (ld_mem_data),
      .ld_data     (ld_data)
   );

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer against a queue-based reference model.
module tb_store_buffer;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          st_valid;
   logic [31:0]   st_addr;
   logic [31:0]   st_data;
   logic          stall;
   logic [31:0]   ld_addr;
   logic [31:0]   ld_data;
   logic [31:0]   ld_mem_addr;
   logic [31:0]   ld_mem_data;
   logic          mem_req;
   logic [31:0]   mem_addr;
   logic [31:0]   mem_wdata;
   logic          mem_ack;
   logic          empty;
   logic [CW-1:0] count;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } ent_t;

   ent_t q[$];

   store_buffer #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .st_valid    (st_valid),
      .st_addr     (st_addr),
      .st_data     (st_data),
      .stall       (stall),
      .ld_addr     (ld_addr),
      .ld_data     (ld_data),
      .ld_mem_addr (ld_mem_addr),
      .ld_mem_data (ld_mem_data),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_ack     (mem_ack),
      .empty       (empty),
      .count       (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Youngest held store to the same word supplies the data, else memory does.
   function automatic logic [31:0] fwd_model(input logic [31:0] la, input logic [31:0] md);
      for (int i = q.size() - 1; i >= 0; i--)
         if (q[i].a[31:2] == la[31:2])
            return q[i].d;
      return md;
   endfunction

   // One clock cycle: drive, check combinational/registered outputs, then advance the model.
   task automatic cyc(input logic v, input logic [31:0] a, input logic [31:0] d,
                      input logic ack, input logic [31:0] la);
      logic full;
      st_valid    = v;
      st_addr     = a;
      st_data     = d;
      mem_ack     = ack;
      ld_addr     = la;
      ld_mem_data = $urandom();
      #2;
      full = (q.size() == DEPTH);
      chk("stall", 32'(stall), 32'(v && full));
      chk("mem_req", 32'(mem_req), 32'(q.size() != 0));
      if (q.size() != 0) begin
         chk("mem_addr", mem_addr, q[0].a);
         chk("mem_wdata", mem_wdata, q[0].d);
      end
      chk("count", 32'(count), 32'(q.size()));
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("ld_mem_addr", ld_mem_addr, la);
      chk("ld_data", ld_data, fwd_model(la, ld_mem_data));
      @(posedge clk);
      if (ack && q.size() != 0)
         void'(q.pop_front());
      if (v && !full)
         q.push_back('{a, d});
      #1;
   endtask

   task automatic do_reset();
      st_valid    = 1'b0;
      mem_ack     = 1'b0;
      ld_addr     = 32'h64;
      ld_mem_data = $urandom();
      reset       = 1'b1;
      #1;
      q.delete();
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_ld_data", ld_data, ld_mem_data);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      repeat (DEPTH + 2) cyc(1'b0, 32'h0, 32'h0, 1'b1, $urandom());
   endtask

   initial begin
      reset       = 1'b0;
      st_valid    = 1'b0;
      st_addr     = '0;
      st_data     = '0;
      mem_ack     = 1'b0;
      ld_addr     = '0;
      ld_mem_data = '0;
      #6;
      do_reset();

      // single store, ack tied high: mem_req next cycle, empty the cycle after
      cyc(1'b1, 32'h60, 32'd7, 1'b1, 32'h60);
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 32'h60);
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 32'h60);

      // fill with ack low, fifth store stalls until a pop has taken effect
      for (int i = 0; i < 5; i++)
         cyc(1'b1, 32'(i * 4), 32'(100 + i), 1'b0, 32'(i * 4));
      cyc(1'b1, 32'h10, 32'd104, 1'b1, 32'h10);
      cyc(1'b1, 32'h10, 32'd104, 1'b0, 32'h10);
      drain();

      // forwarding: youngest match wins, enqueue-cycle store not yet visible
      cyc(1'b1, 32'h64, 32'd25, 1'b0, 32'h64);
      cyc(1'b1, 32'h64, 32'd30, 1'b0, 32'h64);
      cyc(1'b0, 32'h0, 32'h0, 1'b0, 32'h64);
      cyc(1'b0, 32'h0, 32'h0, 1'b0, 32'h68);
      cyc(1'b0, 32'h0, 32'h0, 1'b0, 32'h66);
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 32'h64);
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 32'h64);
      drain();

      // simultaneous enqueue and pop at count 2, then drain order across wrap
      cyc(1'b1, 32'h100, 32'd1, 1'b0, 32'h100);
      cyc(1'b1, 32'h104, 32'd2, 1'b0, 32'h104);
      cyc(1'b1, 32'h108, 32'd3, 1'b1, 32'h100);
      cyc(1'b0, 32'h0, 32'h0, 1'b0, 32'h108);
      for (int i = 0; i < 10; i++) begin
         int tries = 0;
         logic acc;
         do begin
            acc = (q.size() < DEPTH);
            cyc(1'b1, 32'h200 + 32'(i * 4) + 32'($urandom_range(0, 3)), 32'(1000 + i),
                1'($urandom_range(0, 1)) | (q.size() == DEPTH), 32'h200 + 32'($urandom_range(0, 9) * 4));
            tries++;
         end while (!acc && tries < 4);
      end
      drain();

      // reset mid-drain with three entries held
      for (int i = 0; i < 3; i++)
         cyc(1'b1, 32'h64 + 32'(i * 4), 32'(50 + i), 1'b0, 32'h64);
      do_reset();
      repeat (3) cyc(1'b0, 32'h0, 32'h0, 1'b1, 32'h64);

      // randomized traffic over a small address pool
      for (int n = 0; n < 400; n++) begin
         cyc(1'($urandom_range(0, 1)),
             (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3)),
             $urandom(),
             1'($urandom_range(0, 1)),
             (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3)));
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
